// File: rtl/scalar_mult_if.sv
// Handshake bundles for scalar_mult: the host request/result link and the
// operand/result link to the point_add group-operation engine.
interface scalar_mult_if #(
  parameter int NBITS = 448,
  parameter int W     = 448
);
  logic [NBITS-1:0] scalar;
  logic [W-1:0]     bx, by, bt, bz;
  logic             affine;
  logic             req_valid;
  logic             req_ready;
  logic             req_busy;
  logic [W-1:0]     rx, ry, rt, rz;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output scalar, bx, by, bt, bz, affine, req_valid, res_ready,
    input  req_ready, req_busy, rx, ry, rt, rz, res_valid
  );

  modport slave (
    input  scalar, bx, by, bt, bz, affine, req_valid, res_ready,
    output req_ready, req_busy, rx, ry, rt, rz, res_valid
  );
endinterface

interface point_add_if #(
  parameter int W = 448
);
  logic [W-1:0] pa_x1, pa_y1, pa_t1, pa_z1;
  logic [W-1:0] pa_x2, pa_y2, pa_t2, pa_z2;
  logic         pa_affine;
  logic         pa_req_valid;
  logic         pa_req_ready;
  logic         pa_req_busy;
  logic         pa_res_valid;
  logic         pa_res_ready;
  logic [W-1:0] pa_x3, pa_y3, pa_t3, pa_z3;

  modport master (
    output pa_x1, pa_y1, pa_t1, pa_z1, pa_x2, pa_y2, pa_t2, pa_z2,
           pa_affine, pa_req_valid, pa_res_ready,
    input  pa_req_ready, pa_req_busy, pa_res_valid, pa_x3, pa_y3, pa_t3, pa_z3
  );

  modport slave (
    input  pa_x1, pa_y1, pa_t1, pa_z1, pa_x2, pa_y2, pa_t2, pa_z2,
           pa_affine, pa_req_valid, pa_res_ready,
    output pa_req_ready, pa_req_busy, pa_res_valid, pa_x3, pa_y3, pa_t3, pa_z3
  );
endinterface

// File: rtl/scalar_mult.sv
// Constant-time MSB-first double-and-always-add scalar multiplier; every group
// operation is delegated to point_add, this block only sequences and muxes.
module scalar_mult #(
  parameter int NBITS = 448,
  parameter int W     = 448
) (
  input  logic          clk,
  input  logic          rst_n,
  scalar_mult_if.slave  host,
  point_add_if.master   pa
);
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [3:0] {
    IDLE, ACK, INIT, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, SEL, NRM_REQ, NRM_WAIT, POST
  } state_t;

  typedef struct packed {
    logic [W-1:0] x, y, t, z;
  } point_t;

  localparam point_t IDENTITY = {{W{1'b0}}, W'(1), {W{1'b0}}, W'(1)};

  state_t           state;
  point_t           r, s, b, op2, res;
  logic [NBITS-1:0] k;
  logic [IW-1:0]    idx;
  logic             nrm;
  logic             armed;

  assign res = {pa.pa_x3, pa.pa_y3, pa.pa_t3, pa.pa_z3};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op2 = r;
    case (state)
      ADD_REQ: op2 = b;
      NRM_REQ: op2 = IDENTITY;
      default: op2 = r;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // see the pre-edge values of each other regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      r              <= '0;
      s              <= '0;
      b              <= '0;
      k              <= '0;
      idx            <= '0;
      nrm            <= 1'b0;
      armed          <= 1'b0;
      host.req_ready <= 1'b0;
      host.req_busy  <= 1'b0;
      host.res_valid <= 1'b0;
      host.rx        <= '0;
      host.ry        <= '0;
      host.rt        <= '0;
      host.rz        <= '0;
      pa.pa_x1       <= '0;
      pa.pa_y1       <= '0;
      pa.pa_t1       <= '0;
      pa.pa_z1       <= '0;
      pa.pa_x2       <= '0;
      pa.pa_y2       <= '0;
      pa.pa_t2       <= '0;
      pa.pa_z2       <= '0;
      pa.pa_affine   <= 1'b0;
      pa.pa_req_valid <= 1'b0;
      pa.pa_res_ready <= 1'b0;
    end else begin
      host.req_ready  <= 1'b0;
      pa.pa_res_ready <= 1'b0;
      case (state)
        IDLE: if (host.req_valid) begin
          k              <= host.scalar;
          b              <= {host.bx, host.by, host.bt, host.bz};
          nrm            <= host.affine;
          host.req_ready <= 1'b1;
          host.req_busy  <= 1'b1;
          state          <= ACK;
        end
        ACK:  state <= INIT;
        INIT: begin
          r     <= IDENTITY;
          idx   <= IW'(NBITS - 1);
          state <= DBL_REQ;
        end
        // Operands settle one cycle ahead of pa_req_valid and stay put until
        // the next request phase.
        DBL_REQ, ADD_REQ, NRM_REQ: begin
          if (!armed) begin
            {pa.pa_x1, pa.pa_y1, pa.pa_t1, pa.pa_z1} <= r;
            {pa.pa_x2, pa.pa_y2, pa.pa_t2, pa.pa_z2} <= op2;
            pa.pa_affine <= (state == NRM_REQ);
            armed        <= 1'b1;
          end else if (!pa.pa_req_valid) begin
            pa.pa_req_valid <= 1'b1;
          end else if (pa.pa_req_ready) begin
            pa.pa_req_valid <= 1'b0;
            armed           <= 1'b0;
            state <= (state == DBL_REQ) ? DBL_WAIT :
                     (state == ADD_REQ) ? ADD_WAIT : NRM_WAIT;
          end
        end
        DBL_WAIT, ADD_WAIT, NRM_WAIT: if (pa.pa_res_valid && !pa.pa_req_busy) begin
          pa.pa_res_ready <= 1'b1;
          if (state == ADD_WAIT) begin
            s     <= res;
            state <= SEL;
          end else begin
            r     <= res;
            state <= (state == DBL_WAIT) ? ADD_REQ : POST;
          end
        end
        // The sum is always computed; the key bit only steers a register mux.
        SEL: begin
          r <= k[idx] ? s : r;
          if (idx == '0) begin
            state <= nrm ? NRM_REQ : POST;
          end else begin
            idx   <= idx - 1'b1;
            state <= DBL_REQ;
          end
        end
        POST: begin
          if (!host.res_valid) begin
            {host.rx, host.ry, host.rt, host.rz} <= r;
            host.res_valid <= 1'b1;
            host.req_busy  <= 1'b0;
          end else if (host.res_ready) begin
            host.res_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scalar_mult.sv
// Bench for scalar_mult: an abstract additive group stands in for point_add so
// k*B has a closed form; the host side checks results, op counts and protocol.
module tb_scalar_mult;
  localparam int NB = 16;
  localparam int W  = 32;

  typedef struct packed {
    logic [W-1:0] x, y, t, z;
  } pt_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scalar_mult_if #(.NBITS(NB), .W(W)) host ();
  point_add_if   #(.W(W))             pa ();

  scalar_mult #(.NBITS(NB), .W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .host (host),
    .pa   (pa)
  );

  int  n_vec = 0;
  int  n_miss = 0;
  int  pa_ops = 0;
  int  viol = 0;
  int  busy_gap = 0;
  pt_t exp_r;
  int  exp_ops;

  // Stand-in group: (x,y,t,z) with identity (0,1,0,1); x,t add, y-1,z-1 add.
  // Normalisation forces z=1 and t=x*y, mirroring the affine output shape.
  function automatic pt_t grp_add(pt_t p, pt_t q, logic aff);
    pt_t o;
    o.x = p.x + q.x;
    o.y = p.y + q.y - W'(1);
    o.t = p.t + q.t;
    o.z = p.z + q.z - W'(1);
    if (aff) begin
      o.t = o.x * o.y;
      o.z = W'(1);
    end
    return o;
  endfunction

  // Closed form of k*B in that group.
  function automatic pt_t ref_kb(logic [NB-1:0] k, pt_t bp, logic aff);
    logic [W-1:0] kk;
    pt_t q;
    kk  = W'(k);
    q.x = kk * bp.x;
    q.y = kk * (bp.y - W'(1)) + W'(1);
    q.t = kk * bp.t;
    q.z = kk * (bp.z - W'(1)) + W'(1);
    if (aff) begin
      q.t = q.x * q.y;
      q.z = W'(1);
    end
    return q;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // point_add model: accepts, waits a random latency, returns, holds until consumed.
  initial begin : point_add_model
    typedef enum {M_IDLE, M_BUSY, M_DONE} mstate_t;
    mstate_t m_st;
    int      lat;
    logic    prev_valid;
    pt_t     c1, c2;
    logic    caff;
    pt_t     o;
    m_st = M_IDLE;
    lat = 0;
    prev_valid = 1'b0;
    c1 = '0;
    c2 = '0;
    caff = 1'b0;
    pa.pa_req_ready = 1'b0;
    pa.pa_req_busy  = 1'b0;
    pa.pa_res_valid = 1'b0;
    {pa.pa_x3, pa.pa_y3, pa.pa_t3, pa.pa_z3} = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_st = M_IDLE;
        prev_valid = 1'b0;
        pa.pa_req_ready = 1'b0;
        pa.pa_req_busy  = 1'b0;
        pa.pa_res_valid = 1'b0;
        {pa.pa_x3, pa.pa_y3, pa.pa_t3, pa.pa_z3} = '0;
      end else begin
        #1;
        if (pa.pa_req_valid && !prev_valid) pa_ops++;
        prev_valid = pa.pa_req_valid;
        if (pa.pa_req_valid && pa.pa_res_ready) viol++;
        if (m_st != M_IDLE &&
            ({pa.pa_x1, pa.pa_y1, pa.pa_t1, pa.pa_z1} !== c1 ||
             {pa.pa_x2, pa.pa_y2, pa.pa_t2, pa.pa_z2} !== c2 ||
             pa.pa_affine !== caff)) viol++;
        case (m_st)
          M_IDLE: if (pa.pa_req_valid) begin
            c1   = {pa.pa_x1, pa.pa_y1, pa.pa_t1, pa.pa_z1};
            c2   = {pa.pa_x2, pa.pa_y2, pa.pa_t2, pa.pa_z2};
            caff = pa.pa_affine;
            pa.pa_req_ready = 1'b1;
            pa.pa_req_busy  = 1'b1;
            lat  = int'($urandom_range(0, 3));
            m_st = M_BUSY;
          end
          M_BUSY: begin
            pa.pa_req_ready = 1'b0;
            if (lat == 0) begin
              o = grp_add(c1, c2, caff);
              {pa.pa_x3, pa.pa_y3, pa.pa_t3, pa.pa_z3} = o;
              pa.pa_res_valid = 1'b1;
              pa.pa_req_busy  = 1'b0;
              m_st = M_DONE;
            end else begin
              lat--;
            end
          end
          default: if (pa.pa_res_ready) begin
            pa.pa_res_valid = 1'b0;
            m_st = M_IDLE;
          end
        endcase
      end
    end
  end

  task automatic start_req(input logic [NB-1:0] k, input pt_t bp, input logic aff);
    int n;
    exp_r   = ref_kb(k, bp, aff);
    exp_ops = 2 * NB + (aff ? 1 : 0);
    @(negedge clk);
    host.scalar = k;
    {host.bx, host.by, host.bt, host.bz} = bp;
    host.affine = aff;
    host.req_valid = 1'b1;
    pa_ops = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host.req_ready && n < 20);
    host.req_valid = 1'b0;
    check("req_ready", W'(host.req_ready), W'(1));
    check("req_busy", W'(host.req_busy), W'(1));
  endtask

  task automatic finish_req(input string tag, input int hold);
    int n;
    n = 0;
    busy_gap = 0;
    while (!host.res_valid && n < 4000) begin
      if (!host.req_busy) busy_gap++;
      @(negedge clk);
      n++;
    end
    check({tag, ".res_valid"}, W'(host.res_valid), W'(1));
    check({tag, ".busy_fall"}, W'(host.req_busy), W'(0));
    check({tag, ".busy_gap"}, W'(busy_gap), W'(0));
    check({tag, ".rx"}, host.rx, exp_r.x);
    check({tag, ".ry"}, host.ry, exp_r.y);
    check({tag, ".rt"}, host.rt, exp_r.t);
    check({tag, ".rz"}, host.rz, exp_r.z);
    check({tag, ".ops"}, W'(pa_ops), W'(exp_ops));
    check({tag, ".proto"}, W'(viol), W'(0));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, ".hold_valid"}, W'(host.res_valid), W'(1));
      check({tag, ".hold_rx"}, host.rx, exp_r.x);
      check({tag, ".hold_ry"}, host.ry, exp_r.y);
      check({tag, ".hold_rt"}, host.rt, exp_r.t);
      check({tag, ".hold_rz"}, host.rz, exp_r.z);
    end
    host.res_ready = 1'b1;
    @(negedge clk);
    host.res_ready = 1'b0;
    check({tag, ".consumed"}, W'(host.res_valid), W'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"}, W'(host.req_ready), W'(0));
    check({tag, ".req_busy"}, W'(host.req_busy), W'(0));
    check({tag, ".res_valid"}, W'(host.res_valid), W'(0));
    check({tag, ".rx|ry|rt|rz"}, host.rx | host.ry | host.rt | host.rz, W'(0));
    check({tag, ".pa_req_valid"}, W'(pa.pa_req_valid), W'(0));
    check({tag, ".pa_res_ready"}, W'(pa.pa_res_ready), W'(0));
    check({tag, ".pa_op1"}, pa.pa_x1 | pa.pa_y1 | pa.pa_t1 | pa.pa_z1, W'(0));
    check({tag, ".pa_op2"}, pa.pa_x2 | pa.pa_y2 | pa.pa_t2 | pa.pa_z2, W'(0));
    check({tag, ".pa_affine"}, W'(pa.pa_affine), W'(0));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    pt_t g, ord_pt, rb;
    int  seen;
    logic [NB-1:0] rk;
    logic raff;
    // Base point with x,t multiples of 2^24 and y-1,z-1 too: its order is 256.
    g      = '{x: 32'h1234_5679, y: 32'h0bad_f00d, t: 32'h5eed_1234, z: 32'h0000_0001};
    ord_pt = '{x: 32'h0300_0000, y: 32'h0500_0001, t: 32'h0700_0000, z: 32'h0100_0001};

    rst_n = 1'b0;
    host.scalar = '0;
    {host.bx, host.by, host.bt, host.bz} = '0;
    host.affine = 1'b0;
    host.req_valid = 1'b0;
    host.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    start_req(NB'(1), g, 1'b1);
    finish_req("k1_aff", 0);

    start_req(NB'(0), g, 1'b0);
    finish_req("k0_proj", 0);

    start_req(NB'(0), g, 1'b1);
    finish_req("k0_aff", 0);

    start_req(NB'(2), g, 1'b1);
    exp_r = grp_add(g, g, 1'b1);
    finish_req("k2_aff", 0);

    start_req(NB'(256), ord_pt, 1'b1);
    finish_req("k_order", 0);

    start_req({NB{1'b1}}, g, 1'b0);
    finish_req("k_max", 0);

    // A second request while busy must not be accepted or disturb the first.
    rk = NB'($urandom);
    start_req(rk, g, 1'b0);
    host.scalar = ~rk;
    host.req_valid = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (host.req_ready) seen++;
    end
    host.req_valid = 1'b0;
    check("busy_ignore", W'(seen), W'(0));
    finish_req("hold100", 100);

    for (int i = 0; i < 4; i++) begin
      rk   = NB'($urandom);
      raff = 1'($urandom_range(0, 1));
      rb   = '{x: $urandom, y: $urandom, t: $urandom, z: $urandom};
      start_req(rk, rb, raff);
      finish_req($sformatf("rand%0d", i), 0);
    end

    // Abort mid-ladder, then run a fresh request.
    start_req(NB'($urandom), g, 1'b1);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_req(NB'(3), g, 1'b1);
    finish_req("k3_after_reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
